// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Also resolves the MEM-stage branch decision (pcsrc) from the registered payload.
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_aluout,
    input  logic          in_aluzero,
    input  logic [DW-1:0] in_wdata,
    input  logic [RW-1:0] in_wreg,
    input  logic [DW-1:0] in_btarget,
    input  logic [1:0]    in_wb,
    input  logic [2:0]    in_m,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_aluout,
    output logic          out_aluzero,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_wreg,
    output logic [DW-1:0] out_btarget,
    output logic [1:0]    out_wb,
    output logic [2:0]    out_m,
    output logic          pcsrc
);

    typedef struct packed {
        logic [DW-1:0] aluout;
        logic          aluzero;
        logic [DW-1:0] wdata;
        logic [RW-1:0] wreg;
        logic [DW-1:0] btarget;
        logic [1:0]    wb;
        logic [2:0]    m;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;
    logic     accept, retire;

    always_comb begin
        in_pl.aluout  = in_aluout;
        in_pl.aluzero = in_aluzero;
        in_pl.wdata   = in_wdata;
        in_pl.wreg    = in_wreg;
        in_pl.btarget = in_btarget;
        in_pl.wb      = in_wb;
        in_pl.m       = in_m;
    end

    // Handshake flags are pure decodes of the state flop, so out_ready never
    // reaches in_ready combinationally.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != SKID);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_pl;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept && retire) begin
                    main_d = in_pl;
                end else if (retire) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_d  = in_pl;
                    state_d = SKID;
                end
            end
            SKID: begin
                if (retire) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over everything; payload contents are left as don't-care.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_aluout  = main_q.aluout;
    assign out_aluzero = main_q.aluzero;
    assign out_wdata   = main_q.wdata;
    assign out_wreg    = main_q.wreg;
    assign out_btarget = main_q.btarget;
    assign out_wb      = main_q.wb;
    assign out_m       = main_q.m;

    // Asserted for every cycle a taken branch is held; MEM acts on it once.
    assign pcsrc = out_valid & main_q.m[2] & main_q.aluzero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage with a payload scoreboard queue.
module tb_ex_mem_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int PW = 3*DW + RW + 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_aluout = '0;
    logic          in_aluzero = 1'b0;
    logic [DW-1:0] in_wdata = '0;
    logic [RW-1:0] in_wreg = '0;
    logic [DW-1:0] in_btarget = '0;
    logic [1:0]    in_wb = '0;
    logic [2:0]    in_m = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_aluout;
    logic          out_aluzero;
    logic [DW-1:0] out_wdata;
    logic [RW-1:0] out_wreg;
    logic [DW-1:0] out_btarget;
    logic [1:0]    out_wb;
    logic [2:0]    out_m;
    logic          pcsrc;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluout(in_aluout), .in_aluzero(in_aluzero), .in_wdata(in_wdata),
        .in_wreg(in_wreg), .in_btarget(in_btarget), .in_wb(in_wb), .in_m(in_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluout(out_aluout), .out_aluzero(out_aluzero), .out_wdata(out_wdata),
        .out_wreg(out_wreg), .out_btarget(out_btarget), .out_wb(out_wb), .out_m(out_m),
        .pcsrc(pcsrc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] alu;
        logic        zero;
        logic [2:0]  m;
        logic        ov;
        logic        ir;
        logic        pc;
    } vec_t;

    vec_t            vecs[$];
    logic [PW-1:0]   sb[$];
    int              checks = 0;
    int              errors = 0;
    logic            hold_prev = 1'b0;
    logic [PW-1:0]   prev_pl = '0;

    function automatic logic [PW-1:0] mk(input logic [31:0] a, input logic z, input logic [2:0] m);
        logic [RW-1:0] r;
        r = a[4:0] ^ 5'h15;
        return {a, z, ~a, r, a + 32'h4, a[1:0], m};
    endfunction

    function automatic logic [PW-1:0] got_pl();
        return {out_aluout, out_aluzero, out_wdata, out_wreg, out_btarget, out_wb, out_m};
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic add(input logic iv, ordy, fl, input logic [31:0] a, input logic z,
                       input logic [2:0] m, input logic ov, ir, pc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.alu = a; v.zero = z; v.m = m;
        v.ov = ov; v.ir = ir; v.pc = pc;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cyc(input vec_t v, input bit chk_hs, input string tag);
        logic [PW-1:0] e;
        in_valid   = v.iv;
        out_ready  = v.ordy;
        flush      = v.fl;
        in_aluout  = v.alu;
        in_aluzero = v.zero;
        in_wdata   = ~v.alu;
        in_wreg    = v.alu[4:0] ^ 5'h15;
        in_btarget = v.alu + 32'h4;
        in_wb      = v.alu[1:0];
        in_m       = v.m;
        @(negedge clk);
        if (chk_hs) begin
            chk({tag, " out_valid"}, out_valid, v.ov);
            chk({tag, " in_ready"}, in_ready, v.ir);
            chk({tag, " pcsrc"}, pcsrc, v.pc);
        end
        if (hold_prev && out_valid) chk({tag, " stable"}, got_pl(), prev_pl);
        if (v.fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk({tag, " unexpected_out"}, got_pl(), '0);
                    if (got_pl() == '0) begin
                        errors++;
                        $display("FAIL %s unexpected_out got=valid exp=none", tag);
                    end
                end else begin
                    e = sb.pop_front();
                    chk({tag, " data"}, got_pl(), e);
                end
            end
            if (v.iv && in_ready) sb.push_back(mk(v.alu, v.zero, v.m));
        end
        hold_prev = out_valid & ~out_ready & ~v.fl;
        prev_pl   = got_pl();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // streaming
        add(1,1,0,32'h10,0,3'b000, 0,1,0);
        add(1,1,0,32'h20,0,3'b000, 1,1,0);
        add(1,1,0,32'h30,0,3'b000, 1,1,0);
        add(0,1,0,32'h0 ,0,3'b000, 1,1,0);
        // backpressure: C held by the bench until accepted
        add(1,0,0,32'h1111,0,3'b000, 0,1,0);
        add(1,0,0,32'h2222,0,3'b000, 1,1,0);
        add(1,0,0,32'h3333,0,3'b000, 1,0,0);
        add(1,0,0,32'h3333,0,3'b000, 1,0,0);
        add(1,1,0,32'h3333,0,3'b000, 1,0,0);
        add(1,1,0,32'h3333,0,3'b000, 1,1,0);
        add(0,1,0,32'h0   ,0,3'b000, 1,1,0);
        // flush while in SKID with D presented
        add(1,0,0,32'h44,0,3'b000, 0,1,0);
        add(1,0,0,32'h55,0,3'b000, 1,1,0);
        add(1,0,1,32'hDD,0,3'b000, 1,0,0);
        add(0,1,0,32'h0 ,0,3'b000, 0,1,0);
        add(0,1,0,32'h0 ,0,3'b000, 0,1,0);
        // branch taken (also pcsrc=0 while out_valid=0), held over a stall
        add(1,0,0,32'h0,1,3'b100, 0,1,0);
        add(0,0,0,32'h0,0,3'b000, 1,1,1);
        add(0,1,0,32'h0,0,3'b000, 1,1,1);
        // branch not taken
        add(1,1,0,32'h8,0,3'b100, 0,1,0);
        add(0,1,0,32'h0,0,3'b000, 1,1,0);
        // simultaneous accept and retire
        add(1,1,0,32'hA0,0,3'b010, 0,1,0);
        add(1,1,0,32'hA1,0,3'b001, 1,1,0);
        add(1,1,0,32'hA2,1,3'b000, 1,1,0);
        add(1,1,0,32'hA3,0,3'b011, 1,1,0);
        add(1,1,0,32'hA4,1,3'b000, 1,1,0);
        add(1,1,0,32'hA5,0,3'b001, 1,1,0);
        add(0,1,0,32'h0 ,0,3'b000, 1,1,0);
        add(0,1,0,32'h0 ,0,3'b000, 0,1,0);

        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst pcsrc", pcsrc, 1'b0);
        chk("rst payload", got_pl(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], 1'b1, $sformatf("v%0d", i));
        chk("drain", sb.size(), 0);

        // asynchronous reset while two entries are held
        v = vecs[0];
        v.iv = 1; v.ordy = 0; v.fl = 0; v.alu = 32'h77; v.zero = 1; v.m = 3'b100;
        cyc(v, 1'b0, "mr0");
        v.alu = 32'h88; v.zero = 0; v.m = 3'b000;
        cyc(v, 1'b0, "mr1");
        chk("skid out_valid", out_valid, 1'b1);
        chk("skid in_ready", in_ready, 1'b0);
        chk("skid pcsrc", pcsrc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 1'b0);
        chk("arst in_ready", in_ready, 1'b1);
        chk("arst pcsrc", pcsrc, 1'b0);
        chk("arst aluout", out_aluout, '0);
        sb.delete();
        hold_prev = 1'b0;
        rst_n = 1'b1;
        v.iv = 1; v.ordy = 1; v.alu = 32'h99; v.zero = 0; v.m = 3'b000;
        v.ov = 0; v.ir = 1; v.pc = 0;
        cyc(v, 1'b1, "post0");
        v.iv = 0; v.ov = 1;
        cyc(v, 1'b1, "post1");
        v.ov = 0;
        cyc(v, 1'b1, "post2");
        chk("post drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
